// File: rtl/tlb_unit.sv
// Joint instruction/data TLB: combinational fetch translation, E->M registered data translation,
// and tlbp/tlbr/tlbwi/tlbwr support toward CP0. Only 4 KB pages; PageMask is stored, not matched.
module tlb_unit #(
  parameter int unsigned TLB_LINE_NUM = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallM2,
  input  logic        flushM,
  input  logic [3:0]  tlb_typeM,
  input  logic [31:0] entry_hi_W,
  input  logic [31:0] page_mask_W,
  input  logic [31:0] entry_lo0_W,
  input  logic [31:0] entry_lo1_W,
  input  logic [31:0] index_W,
  input  logic [31:0] random_W,
  output logic [31:0] entry_hi_out,
  output logic [31:0] page_mask_out,
  output logic [31:0] entry_lo0_out,
  output logic [31:0] entry_lo1_out,
  output logic [31:0] index_out,
  input  logic [31:0] inst_vaddrF,
  output logic [31:0] inst_paddrF,
  output logic        inst_uncachedF,
  output logic        inst_tlb_refill,
  output logic        inst_tlb_invalid,
  input  logic [31:0] data_vaddrE,
  input  logic        mem_enE,
  input  logic        mem_wenE,
  output logic [31:0] data_paddrM,
  output logic        data_uncachedM,
  output logic        data_tlb_refill,
  output logic        data_tlb_invalid,
  output logic        data_tlb_modify
);

  localparam int unsigned IDX_W = $clog2(TLB_LINE_NUM);

  logic [18:0] vpn2_q [TLB_LINE_NUM];
  logic [7:0]  asid_q [TLB_LINE_NUM];
  logic        g_q    [TLB_LINE_NUM];
  logic [11:0] mask_q [TLB_LINE_NUM];
  logic [19:0] pfn0_q [TLB_LINE_NUM];
  logic [2:0]  c0_q   [TLB_LINE_NUM];
  logic        d0_q   [TLB_LINE_NUM];
  logic        v0_q   [TLB_LINE_NUM];
  logic [19:0] pfn1_q [TLB_LINE_NUM];
  logic [2:0]  c1_q   [TLB_LINE_NUM];
  logic        d1_q   [TLB_LINE_NUM];
  logic        v1_q   [TLB_LINE_NUM];

  // Lowest matching index wins.
  function automatic logic [IDX_W-1:0] first_idx(input logic [TLB_LINE_NUM-1:0] m);
    first_idx = '0;
    for (int i = int'(TLB_LINE_NUM) - 1; i >= 0; i--) begin
      if (m[i]) first_idx = i[IDX_W-1:0];
    end
  endfunction

  // Returns {pa, uncached, miss, invalid}; kseg0/kseg1 bypass the TLB and never flag.
  function automatic logic [34:0] xlate(input logic [31:0] va, input logic hit,
                                        input logic [19:0] pfn, input logic [2:0] c,
                                        input logic v);
    if (va[31:30] == 2'b10) return {3'b000, va[28:0], va[29], 2'b00};
    return {pfn, va[11:0], c != 3'd3, ~hit, hit & ~v};
  endfunction

  logic [TLB_LINE_NUM-1:0] inst_match, data_match, probe_match;

  always_comb begin
    inst_match  = '0;
    data_match  = '0;
    probe_match = '0;
    for (int i = 0; i < int'(TLB_LINE_NUM); i++) begin
      inst_match[i]  = (vpn2_q[i] == inst_vaddrF[31:13]) &&
                       (g_q[i] || asid_q[i] == entry_hi_W[7:0]);
      data_match[i]  = (vpn2_q[i] == data_vaddrE[31:13]) &&
                       (g_q[i] || asid_q[i] == entry_hi_W[7:0]);
      probe_match[i] = (vpn2_q[i] == entry_hi_W[31:13]) &&
                       (g_q[i] || asid_q[i] == entry_hi_W[7:0]);
    end
  end

  // Fetch path
  logic [IDX_W-1:0] i_idx;
  logic             i_hit, i_v;
  logic [19:0]      i_pfn;
  logic [2:0]       i_c;

  always_comb begin
    i_idx = first_idx(inst_match);
    i_hit = |inst_match;
    i_pfn = '0;
    i_c   = '0;
    i_v   = 1'b0;
    if (i_hit) begin
      i_pfn = inst_vaddrF[12] ? pfn1_q[i_idx] : pfn0_q[i_idx];
      i_c   = inst_vaddrF[12] ? c1_q[i_idx]   : c0_q[i_idx];
      i_v   = inst_vaddrF[12] ? v1_q[i_idx]   : v0_q[i_idx];
    end
  end

  assign {inst_paddrF, inst_uncachedF, inst_tlb_refill, inst_tlb_invalid} =
      xlate(inst_vaddrF, i_hit, i_pfn, i_c, i_v);

  // Data path, E stage
  logic [IDX_W-1:0] d_idx;
  logic             d_hit, d_v, d_d, d_mapped;
  logic [19:0]      d_pfn;
  logic [2:0]       d_c;
  logic [31:0]      d_pa;
  logic             d_unc, d_miss, d_inval;

  always_comb begin
    d_idx = first_idx(data_match);
    d_hit = |data_match;
    d_pfn = '0;
    d_c   = '0;
    d_v   = 1'b0;
    d_d   = 1'b0;
    if (d_hit) begin
      d_pfn = data_vaddrE[12] ? pfn1_q[d_idx] : pfn0_q[d_idx];
      d_c   = data_vaddrE[12] ? c1_q[d_idx]   : c0_q[d_idx];
      d_v   = data_vaddrE[12] ? v1_q[d_idx]   : v0_q[d_idx];
      d_d   = data_vaddrE[12] ? d1_q[d_idx]   : d0_q[d_idx];
    end
  end

  assign d_mapped = data_vaddrE[31:30] != 2'b10;
  assign {d_pa, d_unc, d_miss, d_inval} = xlate(data_vaddrE, d_hit, d_pfn, d_c, d_v);

  always_ff @(posedge clk) begin
    if (rst || (!stallM2 && flushM)) begin
      data_paddrM      <= '0;
      data_uncachedM   <= 1'b0;
      data_tlb_refill  <= 1'b0;
      data_tlb_invalid <= 1'b0;
      data_tlb_modify  <= 1'b0;
    end else if (!stallM2) begin
      data_paddrM      <= d_pa;
      data_uncachedM   <= d_unc;
      data_tlb_refill  <= mem_enE & d_miss;
      data_tlb_invalid <= mem_enE & d_inval;
      data_tlb_modify  <= mem_enE & mem_wenE & d_mapped & d_hit & d_v & ~d_d;
    end
  end

  // tlbp / tlbr
  logic [IDX_W-1:0] p_idx, r_idx;

  assign p_idx         = first_idx(probe_match);
  assign index_out     = {~(|probe_match), {(31 - IDX_W){1'b0}}, p_idx};
  assign r_idx         = index_W[IDX_W-1:0];
  assign entry_hi_out  = {vpn2_q[r_idx], 5'b0, asid_q[r_idx]};
  assign page_mask_out = {7'b0, mask_q[r_idx], 13'b0};
  assign entry_lo0_out = {6'b0, pfn0_q[r_idx], c0_q[r_idx], d0_q[r_idx], v0_q[r_idx], g_q[r_idx]};
  assign entry_lo1_out = {6'b0, pfn1_q[r_idx], c1_q[r_idx], d1_q[r_idx], v1_q[r_idx], g_q[r_idx]};

  // tlbwi / tlbwr
  logic             we;
  logic [IDX_W-1:0] w_idx;

  assign we    = !stallM2 && (tlb_typeM[3] || tlb_typeM[2]);
  assign w_idx = tlb_typeM[3] ? random_W[IDX_W-1:0] : index_W[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(TLB_LINE_NUM); i++) begin
        vpn2_q[i] <= '0;
        asid_q[i] <= '0;
        g_q[i]    <= 1'b0;
        mask_q[i] <= '0;
        pfn0_q[i] <= '0;
        c0_q[i]   <= '0;
        d0_q[i]   <= 1'b0;
        v0_q[i]   <= 1'b0;
        pfn1_q[i] <= '0;
        c1_q[i]   <= '0;
        d1_q[i]   <= 1'b0;
        v1_q[i]   <= 1'b0;
      end
    end else if (we) begin
      vpn2_q[w_idx] <= entry_hi_W[31:13];
      asid_q[w_idx] <= entry_hi_W[7:0];
      g_q[w_idx]    <= entry_lo0_W[0] & entry_lo1_W[0];
      mask_q[w_idx] <= page_mask_W[24:13];
      pfn0_q[w_idx] <= entry_lo0_W[25:6];
      c0_q[w_idx]   <= entry_lo0_W[5:3];
      d0_q[w_idx]   <= entry_lo0_W[2];
      v0_q[w_idx]   <= entry_lo0_W[1];
      pfn1_q[w_idx] <= entry_lo1_W[25:6];
      c1_q[w_idx]   <= entry_lo1_W[5:3];
      d1_q[w_idx]   <= entry_lo1_W[2];
      v1_q[w_idx]   <= entry_lo1_W[1];
    end
  end

  logic unused_bits;
  assign unused_bits = ^{entry_hi_W[12:8], page_mask_W[31:25], page_mask_W[12:0],
                         entry_lo0_W[31:26], entry_lo1_W[31:26], index_W[31:IDX_W],
                         random_W[31:IDX_W], tlb_typeM[1:0]};

endmodule

// File: tb/tb_tlb_unit.sv
// Scoreboard bench for tlb_unit: stimulus pushes expectations, a negedge monitor pops and compares.
module tb_tlb_unit;

  logic        clk;
  logic        rst;
  logic        stallM2, flushM;
  logic [3:0]  tlb_typeM;
  logic [31:0] entry_hi_W, page_mask_W, entry_lo0_W, entry_lo1_W, index_W, random_W;
  logic [31:0] entry_hi_out, page_mask_out, entry_lo0_out, entry_lo1_out, index_out;
  logic [31:0] inst_vaddrF, inst_paddrF;
  logic        inst_uncachedF, inst_tlb_refill, inst_tlb_invalid;
  logic [31:0] data_vaddrE, data_paddrM;
  logic        mem_enE, mem_wenE;
  logic        data_uncachedM, data_tlb_refill, data_tlb_invalid, data_tlb_modify;

  tlb_unit #(.TLB_LINE_NUM(16)) dut (
    .clk(clk), .rst(rst), .stallM2(stallM2), .flushM(flushM), .tlb_typeM(tlb_typeM),
    .entry_hi_W(entry_hi_W), .page_mask_W(page_mask_W), .entry_lo0_W(entry_lo0_W),
    .entry_lo1_W(entry_lo1_W), .index_W(index_W), .random_W(random_W),
    .entry_hi_out(entry_hi_out), .page_mask_out(page_mask_out),
    .entry_lo0_out(entry_lo0_out), .entry_lo1_out(entry_lo1_out), .index_out(index_out),
    .inst_vaddrF(inst_vaddrF), .inst_paddrF(inst_paddrF), .inst_uncachedF(inst_uncachedF),
    .inst_tlb_refill(inst_tlb_refill), .inst_tlb_invalid(inst_tlb_invalid),
    .data_vaddrE(data_vaddrE), .mem_enE(mem_enE), .mem_wenE(mem_wenE),
    .data_paddrM(data_paddrM), .data_uncachedM(data_uncachedM),
    .data_tlb_refill(data_tlb_refill), .data_tlb_invalid(data_tlb_invalid),
    .data_tlb_modify(data_tlb_modify)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind 0 = fetch, 1 = tlbp, 2 = tlbr, 3 = data M register
  typedef struct {
    string       nm;
    int          kind;
    logic [31:0] a, b, c, d;
    bit          dc;
  } exp_t;

  exp_t cq[$];
  exp_t dq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic vld_e = 1'b0;
  logic vld_m = 1'b0;

  // Tracks which cycles carry a data expectation into M, frozen by stall like the DUT.
  always @(posedge clk) begin
    if (rst || !stallM2) vld_m <= vld_e;
  end

  task automatic check_comb(input exp_t e);
    bit ok;
    checks++;
    case (e.kind)
      0: begin
        ok = e.dc ? ({inst_tlb_refill, inst_tlb_invalid} == e.b[1:0])
                  : (inst_paddrF == e.a &&
                     {inst_uncachedF, inst_tlb_refill, inst_tlb_invalid} == e.b[2:0]);
        if (!ok) $display("FAIL %s: got pa=%h unc/ref/inv=%b, want pa=%h unc/ref/inv=%b",
                          e.nm, inst_paddrF, {inst_uncachedF, inst_tlb_refill,
                          inst_tlb_invalid}, e.a, e.b[2:0]);
      end
      1: begin
        ok = (index_out == e.a);
        if (!ok) $display("FAIL %s: got index=%h, want %h", e.nm, index_out, e.a);
      end
      default: begin
        ok = (entry_hi_out == e.a && page_mask_out == e.b && entry_lo0_out == e.c &&
              entry_lo1_out == e.d);
        if (!ok) $display("FAIL %s: got hi=%h pm=%h lo0=%h lo1=%h, want %h %h %h %h", e.nm,
                          entry_hi_out, page_mask_out, entry_lo0_out, entry_lo1_out,
                          e.a, e.b, e.c, e.d);
      end
    endcase
    if (!ok) errors++;
  endtask

  task automatic check_data(input exp_t e);
    logic [3:0] got_f;
    bit ok;
    got_f = {data_uncachedM, data_tlb_refill, data_tlb_invalid, data_tlb_modify};
    checks++;
    ok = e.dc ? (got_f[2:0] == e.b[2:0]) : (data_paddrM == e.a && got_f == e.b[3:0]);
    if (!ok) begin
      errors++;
      $display("FAIL %s: got pa=%h unc/ref/inv/mod=%b, want pa=%h unc/ref/inv/mod=%b",
               e.nm, data_paddrM, got_f, e.a, e.b[3:0]);
    end
  endtask

  always @(negedge clk) begin
    while (cq.size() > 0) begin
      mon_e = cq.pop_front();
      check_comb(mon_e);
    end
    if (vld_m) begin
      if (dq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL data_queue: got M result with no expectation, want one queued");
      end else begin
        mon_e = dq.pop_front();
        check_data(mon_e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input exp_t e, input bit data);
    if (data) dq.push_back(e);
    else cq.push_back(e);
  endtask

  task automatic dacc(input string nm, input logic [31:0] va, input logic en, input logic wen,
                      input logic [31:0] pa, input logic [3:0] f, input bit dc);
    exp_t e;
    data_vaddrE = va;
    mem_enE = en;
    mem_wenE = wen;
    vld_e = 1'b1;
    e.nm = nm; e.kind = 3; e.a = pa; e.b = {28'b0, f}; e.c = '0; e.d = '0; e.dc = dc;
    push(e, 1'b1);
    step();
    vld_e = 1'b0;
    mem_enE = 1'b0;
    mem_wenE = 1'b0;
  endtask

  task automatic fchk(input string nm, input logic [31:0] va, input logic [31:0] pa,
                      input logic [2:0] f, input bit dc);
    exp_t e;
    inst_vaddrF = va;
    e.nm = nm; e.kind = 0; e.a = pa; e.b = {29'b0, f}; e.c = '0; e.d = '0; e.dc = dc;
    push(e, 1'b0);
    step();
  endtask

  task automatic pchk(input string nm, input logic [31:0] hi, input logic [31:0] idx);
    exp_t e;
    entry_hi_W = hi;
    e.nm = nm; e.kind = 1; e.a = idx; e.b = '0; e.c = '0; e.d = '0; e.dc = 1'b0;
    push(e, 1'b0);
    step();
  endtask

  task automatic rchk(input string nm, input logic [31:0] idx, input logic [31:0] hi,
                      input logic [31:0] pm, input logic [31:0] l0, input logic [31:0] l1);
    exp_t e;
    index_W = idx;
    e.nm = nm; e.kind = 2; e.a = hi; e.b = pm; e.c = l0; e.d = l1; e.dc = 1'b0;
    push(e, 1'b0);
    step();
  endtask

  task automatic set_w(input logic [3:0] typ, input logic [31:0] hi, input logic [31:0] pm,
                       input logic [31:0] l0, input logic [31:0] l1, input logic [31:0] idx,
                       input logic [31:0] rnd);
    tlb_typeM = typ; entry_hi_W = hi; page_mask_W = pm;
    entry_lo0_W = l0; entry_lo1_W = l1; index_W = idx; random_W = rnd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stallM2 = 1'b0; flushM = 1'b0; tlb_typeM = '0;
    entry_hi_W = 32'h0000_0005; page_mask_W = '0; entry_lo0_W = '0; entry_lo1_W = '0;
    index_W = '0; random_W = '0; inst_vaddrF = '0; data_vaddrE = '0;
    mem_enE = 1'b0; mem_wenE = 1'b0;
    step();
    dacc("reset_m", 32'h0040_0000, 1'b1, 1'b0, 32'h0, 4'b0000, 1'b0);
    rst = 1'b0;

    // Empty TLB: mapped accesses miss, unmapped segments translate without flags
    dacc("refill_empty", 32'h0040_0000, 1'b1, 1'b0, 32'h0, 4'b1100, 1'b0);
    fchk("fetch_refill_empty", 32'h0040_0000, 32'h0, 3'b110, 1'b0);
    dacc("kseg0_data", 32'h8000_1234, 1'b1, 1'b0, 32'h0000_1234, 4'b0000, 1'b0);
    dacc("kseg1_data", 32'hBFC0_0000, 1'b1, 1'b0, 32'h1FC0_0000, 4'b1000, 1'b0);
    fchk("kseg0_fetch", 32'h8000_1234, 32'h0000_1234, 3'b000, 1'b0);
    fchk("kseg1_fetch", 32'hBFC0_0000, 32'h1FC0_0000, 3'b100, 1'b0);

    // tlbwi entry 3; the lookup in the write cycle still sees the old (empty) entry
    set_w(4'b0100, 32'h0040_0005, 32'h0000_6000, 32'h0000_1016, 32'h0000_2004, 32'd3, 32'd0);
    dacc("read_during_write", 32'h0040_0A10, 1'b1, 1'b0, 32'h0, 4'b0100, 1'b1);
    tlb_typeM = '0;
    dacc("load_even", 32'h0040_0A10, 1'b1, 1'b0, 32'h0004_0A10, 4'b1000, 1'b0);
    dacc("load_odd_invalid", 32'h0040_1A10, 1'b1, 1'b0, 32'h0008_0A10, 4'b1010, 1'b0);
    dacc("invalid_no_en", 32'h0040_1A10, 1'b0, 1'b0, 32'h0008_0A10, 4'b1000, 1'b0);
    entry_hi_W = 32'h0040_0006;
    dacc("asid_miss", 32'h0040_0A10, 1'b1, 1'b0, 32'h0, 4'b0100, 1'b1);
    entry_hi_W = 32'h0040_0005;
    fchk("fetch_even", 32'h0040_0A10, 32'h0004_0A10, 3'b100, 1'b0);
    fchk("fetch_odd_invalid", 32'h0040_1A10, 32'h0008_0A10, 3'b101, 1'b0);

    // Entry 4: clean (D=0) page, lo1 G=1 but lo0 G=0 so stored G=0
    set_w(4'b0100, 32'h0060_0005, 32'h0, 32'h0000_155A, 32'h0000_155B, 32'd4, 32'd0);
    step();
    tlb_typeM = '0;
    dacc("store_modify", 32'h0060_0123, 1'b1, 1'b1, 32'h0005_5123, 4'b0001, 1'b0);
    dacc("load_clean", 32'h0060_0123, 1'b1, 1'b0, 32'h0005_5123, 4'b0000, 1'b0);
    rchk("tlbr_4_gand", 32'd4, 32'h0060_0005, 32'h0, 32'h0000_155A, 32'h0000_155A);

    pchk("tlbp_hit_3", 32'h0040_0005, 32'h0000_0003);
    pchk("tlbp_miss", 32'h0070_0005, 32'h8000_0000);
    entry_hi_W = 32'h0040_0005;
    rchk("tlbr_3", 32'd3, 32'h0040_0005, 32'h0000_6000, 32'h0000_1016, 32'h0000_2004);

    // Duplicate VPN2 at entry 1: lowest index wins
    set_w(4'b0100, 32'h0040_0005, 32'h0, 32'h0000_045E, 32'h0, 32'd1, 32'd0);
    step();
    tlb_typeM = '0;
    pchk("tlbp_lowest", 32'h0040_0005, 32'h0000_0001);
    dacc("data_lowest", 32'h0040_0A10, 1'b1, 1'b0, 32'h0001_1A10, 4'b0000, 1'b0);

    flushM = 1'b1;
    dacc("flush", 32'h0040_0A10, 1'b1, 1'b0, 32'h0, 4'b0000, 1'b0);
    flushM = 1'b0;

    // Stall holds M and blocks the tlbwr
    dacc("pre_stall", 32'h0060_0123, 1'b1, 1'b0, 32'h0005_5123, 4'b0000, 1'b0);
    stallM2 = 1'b1;
    set_w(4'b1000, 32'h0080_0005, 32'h0, 32'h0000_1DDF, 32'h0000_1E1F, 32'd0, 32'd15);
    dacc("stall_hold1", 32'h0040_1A10, 1'b1, 1'b0, 32'h0005_5123, 4'b0000, 1'b0);
    dacc("stall_hold2", 32'h0060_0123, 1'b1, 1'b1, 32'h0005_5123, 4'b0000, 1'b0);
    stallM2 = 1'b0;
    tlb_typeM = '0;
    entry_hi_W = 32'h0000_0009;
    fchk("stall_no_write", 32'h0080_0ABC, 32'h0, 3'b010, 1'b1);
    rchk("tlbr_15_empty", 32'd15, 32'h0, 32'h0, 32'h0, 32'h0);

    set_w(4'b1000, 32'h0080_0005, 32'h0, 32'h0000_1DDF, 32'h0000_1E1F, 32'd0, 32'd15);
    fchk("tlbwr_same_cycle", 32'h0080_0ABC, 32'h0, 3'b010, 1'b1);
    tlb_typeM = '0;
    entry_hi_W = 32'h0000_0009;
    fchk("tlbwr_hit_even", 32'h0080_0ABC, 32'h0007_7ABC, 3'b000, 1'b0);
    fchk("tlbwr_hit_odd", 32'h0080_1ABC, 32'h0007_8ABC, 3'b000, 1'b0);
    rchk("tlbr_15", 32'd15, 32'h0080_0005, 32'h0, 32'h0000_1DDF, 32'h0000_1E1F);

    // Reset during a stall still clears M and the entries
    stallM2 = 1'b1;
    rst = 1'b1;
    dacc("rst_in_stall", 32'h0040_0A10, 1'b1, 1'b0, 32'h0, 4'b0000, 1'b0);
    rst = 1'b0;
    stallM2 = 1'b0;
    pchk("tlbp_after_rst", 32'h0040_0005, 32'h8000_0000);
    entry_hi_W = 32'h0000_0009;
    fchk("fetch_after_rst", 32'h0080_0ABC, 32'h0, 3'b010, 1'b1);

    step();
    step();
    if (cq.size() != 0 || dq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d/%0d pending expectations, want 0/0", cq.size(), dq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
